// File: rtl/mem_pkg.sv
// mem_pkg: access-size encoding, strobe/alignment helpers and response record for data_memory_be.
package mem_pkg;
   localparam int MAX_DW = 64;
   typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_t;
   typedef struct packed {
      logic              valid;
      logic              misaligned;
      logic [MAX_DW-1:0] rdata;
   } mem_resp_t;
   function automatic int unsigned size_bytes(mem_size_t s);
      return 32'd1 << s;
   endfunction
   function automatic logic [7:0] byte_strobe(mem_size_t s, logic [2:0] ofs);
      logic [8:0] m;
      m = (9'd1 << size_bytes(s)) - 9'd1;
      return m[7:0] << ofs;
   endfunction
   function automatic logic is_misaligned(mem_size_t s, logic [2:0] ofs, int dw);
      return (s == MEM_D && dw == 32) || ((ofs & 3'(size_bytes(s) - 1)) != 3'd0);
   endfunction
endpackage

// File: rtl/bram_be.sv
// bram_be: single-port read-first RAM with per-byte write enables; storage only so it maps onto BRAM.
module bram_be #(
   parameter int    DATA_WIDTH = 32,
   parameter int    DEPTH      = 1024,
   parameter string INIT_FILE  = "",
   localparam int   NB         = DATA_WIDTH / 8,
   localparam int   IW         = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  en_i,
   input  logic [NB-1:0]         we_i,
   input  logic [IW-1:0]         addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int i = 0; i < NB; i++)
            if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         rdata_o <= mem_q[addr_i];
      end
   end
endmodule

// File: rtl/data_memory_be.sv
// data_memory_be: byte-addressed load/store memory with strobed stores, load extension,
// misalignment faults and an in-order 1- or 2-cycle response pipeline.
module data_memory_be
   import mem_pkg::*;
#(
   parameter int    DATA_WIDTH   = 32,
   parameter int    DEPTH        = 1024,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = "",
   localparam int   NB           = DATA_WIDTH / 8,
   localparam int   OFS_W        = $clog2(NB),
   localparam int   ADDR_WIDTH   = $clog2(DEPTH) + OFS_W
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  REQ_VALID,
   input  logic                  REQ_WRITE,
   input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [1:0]            REQ_SIZE,
   input  logic                  REQ_UNSIGNED,
   input  logic [DATA_WIDTH-1:0] REQ_WDATA,
   output logic                  RESP_VALID,
   output logic [DATA_WIDTH-1:0] RESP_RDATA,
   output logic                  RESP_MISALIGNED
);
   mem_size_t             req_size, size1_q;
   logic [OFS_W-1:0]      ofs, ofs1_q;
   logic [7:0]            strb;
   logic                  fault, rd_en;
   logic [NB-1:0]         we;
   logic [DATA_WIDTH-1:0] wdata_sh, raw, sh, mask, ext;
   logic                  v1_q, mis1_q, ld1_q, uns1_q;
   mem_resp_t             resp1_d, resp_o;

   assign req_size = mem_size_t'(REQ_SIZE);
   assign ofs      = REQ_ADDR[OFS_W-1:0];
   assign fault    = is_misaligned(req_size, 3'(ofs), DATA_WIDTH);
   assign strb     = byte_strobe(req_size, 3'(ofs));
   assign rd_en    = REQ_VALID && !fault;
   assign we       = (rd_en && REQ_WRITE) ? strb[NB-1:0] : '0;
   assign wdata_sh = REQ_WDATA << {ofs, 3'b000};

   bram_be #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .INIT_FILE(INIT_FILE)) u_bram (
      .clk_i   (CLK),
      .en_i    (rd_en),
      .we_i    (we),
      .addr_i  (REQ_ADDR[ADDR_WIDTH-1:OFS_W]),
      .wdata_i (wdata_sh),
      .rdata_o (raw)
   );

   // Request attributes only move on valid requests so an idle slot keeps the last response
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         v1_q    <= 1'b0;
         mis1_q  <= 1'b0;
         ld1_q   <= 1'b0;
         uns1_q  <= 1'b0;
         ofs1_q  <= '0;
         size1_q <= MEM_B;
      end else begin
         v1_q <= REQ_VALID;
         if (REQ_VALID) begin
            mis1_q  <= fault;
            ld1_q   <= !REQ_WRITE;
            uns1_q  <= REQ_UNSIGNED;
            ofs1_q  <= ofs;
            size1_q <= req_size;
         end
      end
   end

   always_comb begin
      sh   = raw >> {ofs1_q, 3'b000};
      mask = size1_q == MEM_B ? DATA_WIDTH'(8'hFF) :
             size1_q == MEM_H ? DATA_WIDTH'(16'hFFFF) :
             size1_q == MEM_W ? DATA_WIDTH'(32'hFFFF_FFFF) : '1;
      ext  = (sh & mask) | ((!uns1_q && |(sh & (mask ^ (mask >> 1)))) ? ~mask : '0);
      resp1_d = {v1_q, mis1_q, MAX_DW'((ld1_q && !mis1_q) ? ext : '0)};
   end

   if (READ_LATENCY == 2) begin : g_lat2
      mem_resp_t resp2_q;
      always_ff @(posedge CLK or negedge RSTN) begin
         if (!RSTN) begin
            resp2_q <= '0;
         end else begin
            resp2_q.valid <= resp1_d.valid;
            if (resp1_d.valid) begin
               resp2_q.misaligned <= resp1_d.misaligned;
               resp2_q.rdata      <= resp1_d.rdata;
            end
         end
      end
      assign resp_o = resp2_q;
   end else begin : g_lat1
      assign resp_o = resp1_d;
   end

   assign RESP_VALID      = resp_o.valid;
   assign RESP_MISALIGNED = resp_o.misaligned;
   assign RESP_RDATA      = resp_o.rdata[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_data_memory_be.sv
// tb_data_memory_be: drives one request stream into a 32-bit/1-cycle and a 64-bit/2-cycle memory
// and checks both against a byte-array model every cycle, plus hand-computed load results.
module tb_data_memory_be;
   typedef struct packed {logic v; logic mis; logic [63:0] rd;} exp_t;
   localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, D = 2'd3;

   logic        clk = 0, rstn = 0, rv = 0, rw = 0, ru = 0;
   logic [11:0] ra = '0;
   logic [1:0]  rs = '0;
   logic [63:0] wd = '0;
   logic        v32, m32, v64, m64;
   logic [31:0] d32;
   logic [63:0] d64;
   bit   [7:0]  mm [2][4096];
   exp_t        out32 = '0, out64 = '0, pend64 = '0;
   int          checks = 0, errors = 0;
   bit          chk_en = 0;

   always #5 clk = ~clk;

   data_memory_be #(.DATA_WIDTH(32), .DEPTH(1024), .READ_LATENCY(1)) u32 (
      .CLK(clk), .RSTN(rstn), .REQ_VALID(rv), .REQ_WRITE(rw), .REQ_ADDR(ra), .REQ_SIZE(rs),
      .REQ_UNSIGNED(ru), .REQ_WDATA(wd[31:0]), .RESP_VALID(v32), .RESP_RDATA(d32),
      .RESP_MISALIGNED(m32));
   data_memory_be #(.DATA_WIDTH(64), .DEPTH(512), .READ_LATENCY(2)) u64 (
      .CLK(clk), .RSTN(rstn), .REQ_VALID(rv), .REQ_WRITE(rw), .REQ_ADDR(ra), .REQ_SIZE(rs),
      .REQ_UNSIGNED(ru), .REQ_WDATA(wd), .RESP_VALID(v64), .RESP_RDATA(d64),
      .RESP_MISALIGNED(m64));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Byte-level reference: k = 0 is the 32-bit memory, k = 1 the 64-bit one
   task automatic model(input int k, output exp_t e);
      int nb;
      logic [63:0] r;
      nb = 1 << rs;
      r  = '0;
      e  = '0;
      e.v = rv;
      if (!rv) return;
      e.mis = (rs == D && k == 0) || (int'(ra) % nb != 0);
      if (e.mis) return;
      if (rw) begin
         for (int i = 0; i < nb; i++) mm[k][int'(ra) + i] = wd[8*i +: 8];
      end else begin
         for (int i = 0; i < nb; i++) r[8*i +: 8] = mm[k][int'(ra) + i];
         if (!ru && r[8*nb-1]) for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
         if (k == 0) r[63:32] = '0;
         e.rd = r;
      end
   endtask

   task automatic step(input logic v, input logic w, input logic [11:0] a, input logic [1:0] s,
                       input logic u, input logic [63:0] d);
      exp_t e0, e1;
      rv = v; rw = w; ra = a; rs = s; ru = u; wd = d;
      model(0, e0);
      model(1, e1);
      @(posedge clk);
      out32.v = e0.v;
      if (e0.v) begin out32.mis = e0.mis; out32.rd = e0.rd; end
      out64.v = pend64.v;
      if (pend64.v) begin out64.mis = pend64.mis; out64.rd = pend64.rd; end
      pend64 = e1;
      #1;
      rv = 0;
   endtask

   task automatic st(input logic [11:0] a, input logic [1:0] s, input logic [63:0] d);
      step(1, 1, a, s, 0, d);
   endtask
   task automatic ld(input logic [11:0] a, input logic [1:0] s, input logic u);
      step(1, 0, a, s, u, '0);
   endtask
   task automatic idle();
      step(0, 0, '0, B, 0, '0);
   endtask

   task automatic lit32(input string n, input logic mis, input logic [31:0] d);
      chk({n, ".valid"}, 64'(v32), 64'd1);
      chk({n, ".mis"}, 64'(m32), 64'(mis));
      chk({n, ".rdata"}, 64'(d32), 64'(d));
   endtask
   task automatic lit64(input string n, input logic mis, input logic [63:0] d);
      chk({n, ".valid"}, 64'(v64), 64'd1);
      chk({n, ".mis"}, 64'(m64), 64'(mis));
      chk({n, ".rdata"}, d64, d);
   endtask

   task automatic zero_outs(input string n);
      chk({n, ".v32"}, 64'(v32), 64'd0);
      chk({n, ".d32"}, 64'(d32), 64'd0);
      chk({n, ".m32"}, 64'(m32), 64'd0);
      chk({n, ".v64"}, 64'(v64), 64'd0);
      chk({n, ".d64"}, d64, 64'd0);
      chk({n, ".m64"}, 64'(m64), 64'd0);
   endtask

   task automatic do_reset();
      rstn = 0; rv = 0;
      out32 = '0; out64 = '0; pend64 = '0;
      #1;
      zero_outs("rst_mid");
      repeat (2) @(posedge clk);
      #1;
      rstn = 1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc.v32", 64'(v32), 64'(out32.v));
         chk("cyc.m32", 64'(m32), 64'(out32.mis));
         chk("cyc.d32", 64'(d32), out32.rd);
         chk("cyc.v64", 64'(v64), 64'(out64.v));
         chk("cyc.m64", 64'(m64), 64'(out64.mis));
         chk("cyc.d64", d64, out64.rd);
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      zero_outs("rst_init");
      rstn   = 1;
      chk_en = 1;
      st(12'h000, W, 64'h8899AABB);
      ld(12'h000, W, 0);
      lit32("lw0", 0, 32'h8899AABB);
      idle();
      lit64("lw0_64", 0, 64'hFFFFFFFF_8899AABB);
      ld(12'h000, W, 1);
      do_reset();
      idle();
      idle();
      ld(12'h000, W, 0);
      lit32("lw0_after_rst", 0, 32'h8899AABB);
      st(12'h004, B, 64'h11);
      st(12'h005, B, 64'h22);
      st(12'h006, H, 64'h4433);
      ld(12'h004, W, 0);
      lit32("lw4", 0, 32'h44332211);
      st(12'h008, W, 64'h80FF7F01);
      ld(12'h009, B, 0);
      lit32("lb9", 0, 32'h0000007F);
      ld(12'h00A, B, 0);
      lit32("lbA", 0, 32'hFFFFFFFF);
      ld(12'h00A, B, 1);
      lit32("lbuA", 0, 32'h000000FF);
      ld(12'h00A, H, 0);
      lit32("lhA", 0, 32'hFFFF80FF);
      ld(12'h00A, H, 1);
      lit32("lhuA", 0, 32'h000080FF);
      st(12'h00C, W, 64'hCAFEF00D);
      st(12'h00D, W, 64'hDEADBEEF);
      lit32("swD_fault", 1, 32'h0);
      ld(12'h00C, W, 1);
      lit32("lwC_kept", 0, 32'hCAFEF00D);
      ld(12'h003, H, 0);
      lit32("lh3_fault", 1, 32'h0);
      st(12'h020, D, 64'h1122334455667788);
      lit32("sd_on_32", 1, 32'h0);
      st(12'h010, W, 64'h12345678);
      ld(12'h010, W, 1);
      lit32("lw10_next", 0, 32'h12345678);
      ld(12'h000, W, 0);
      lit32("b2b0", 0, 32'h8899AABB);
      ld(12'h004, W, 0);
      lit32("b2b1", 0, 32'h44332211);
      ld(12'h008, W, 0);
      lit32("b2b2", 0, 32'h80FF7F01);
      ld(12'h00C, W, 0);
      lit32("b2b3", 0, 32'hCAFEF00D);
      st(12'h01C, W, 64'h5A5A5A5A);
      st(12'h018, D, 64'h01234567_89ABCDEF);
      ld(12'h01C, W, 0);
      lit32("lw1C_32", 0, 32'h5A5A5A5A);
      lit64("sd18_resp", 0, 64'h0);
      idle();
      lit64("lw1C_64", 0, 64'h00000000_01234567);
      ld(12'h018, D, 0);
      lit32("ld_on_32", 1, 32'h0);
      idle();
      lit64("ld18_64", 0, 64'h01234567_89ABCDEF);
      repeat (3) idle();
      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
